// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: address map, MMIO register offsets and region decode for dmem_mmio
package mips_mem_pkg;
  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [23:0] MMIO_BASE = 24'hFFFF00;
  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_CNT  = 8'h04;
  localparam logic [7:0] OFF_CMP  = 8'h08;
  localparam logic [7:0] OFF_CTRL = 8'h0C;
  localparam logic [7:0] OFF_STAT = 8'h10;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_t;
  function automatic region_t decode(input logic [31:0] a, input int unsigned words);
    return (a[31:16] == RAM_BASE && {18'd0, a[15:2]} < words) ? REG_RAM :
           (a[31:8] == MMIO_BASE) ? REG_MMIO : REG_NONE;
  endfunction
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled compare timer with sticky match flag and its register read mux
module mmio_timer import mips_mem_pkg::*; #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [5:0]  woff,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [31:0] cnt, cmp;
  logic [2:0] ctrl;
  logic match;
  logic [PW-1:0] pre;
  logic wr_cnt, wr_cmp, wr_ctrl, wr_stat, tick, hit;
  always_comb begin
    wr_cnt  = we && woff == OFF_CNT[7:2];
    wr_cmp  = we && woff == OFF_CMP[7:2];
    wr_ctrl = we && woff == OFF_CTRL[7:2];
    wr_stat = we && woff == OFF_STAT[7:2];
    tick    = ctrl[CTRL_EN] && pre == PMAX;
    hit     = tick && cnt == cmp;
    irq     = match && ctrl[CTRL_IRQEN];
    rdata   = woff == OFF_CNT[7:2]  ? cnt :
              woff == OFF_CMP[7:2]  ? cmp :
              woff == OFF_CTRL[7:2] ? {29'd0, ctrl} :
              woff == OFF_STAT[7:2] ? {31'd0, match} : '0;
  end
  // A CPU write to CNT overrides the tick and restarts the prescale period
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      cmp   <= '1;
      ctrl  <= '0;
      match <= 1'b0;
      pre   <= '0;
    end else begin
      pre   <= (wr_cnt || !ctrl[CTRL_EN] || tick) ? '0 : pre + 1'b1;
      cnt   <= wr_cnt ? wdata : (hit && ctrl[CTRL_AUTO]) ? '0 : tick ? cnt + 32'd1 : cnt;
      match <= hit || (match && !(wr_stat && wdata[0]));
      if (wr_cmp) cmp <= wdata;
      if (wr_ctrl) ctrl <= wdata[2:0];
    end
  end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus MMIO page (LED register, timer) with combinational loads
module dmem_mmio import mips_mem_pkg::*; #(
  parameter int RAM_WORDS = 64,
  parameter int PRESCALE  = 1,
  parameter int LED_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] trd;
  region_t region;
  logic mmio_we, unused_lo;
  assign region    = decode(addr, RAM_WORDS);
  assign mmio_we   = memwrite && region == REG_MMIO;
  assign unused_lo = ^addr[1:0];
  assign readdata  = region == REG_RAM ? ram[addr[AW+1:2]] :
                     region != REG_MMIO ? '0 :
                     addr[7:2] == OFF_LED[7:2] ? 32'(leds) : trd;
  // RAM keeps its contents across reset
  always_ff @(posedge clk)
    if (memwrite && region == REG_RAM) ram[addr[AW+1:2]] <= writedata;
  always_ff @(posedge clk)
    if (reset) leds <= '0;
    else if (mmio_we && addr[7:2] == OFF_LED[7:2]) leds <= writedata[LED_W-1:0];
  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk(clk),
    .reset(reset),
    .we(mmio_we),
    .woff(addr[7:2]),
    .wdata(writedata),
    .rdata(trd),
    .irq(timer_irq)
  );
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: vector table plus timed timer sequences, scoreboard checked on the falling edge
module tb_dmem_mmio;
  logic clk = 1'b0, reset = 1'b1, memwrite = 1'b0;
  logic [31:0] addr = '0, writedata = '0;
  logic [31:0] rd1, rd4;
  logic [15:0] leds1, leds4;
  logic irq1, irq4;
  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
  localparam logic [31:0] A_STAT = 32'hFFFF_0010;
  dmem_mmio #(.PRESCALE(1)) u1 (.clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(rd1), .leds(leds1), .timer_irq(irq1));
  dmem_mmio #(.PRESCALE(4)) u4 (.clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(rd4), .leds(leds4), .timer_irq(irq4));
  always #5 clk = ~clk;
  typedef struct {string name; int sel; int kind; logic [31:0] exp;} exp_t;
  typedef struct {int op; int sel; logic [31:0] a; logic [31:0] d; logic [31:0] x; string name;} vec_t;
  exp_t q[$];
  vec_t tbl[$];
  int total = 0, bad = 0, ne = 0, e0 = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = e.kind == 1 ? (e.sel != 0 ? rd4 : rd1) :
            e.kind == 2 ? 32'(e.sel != 0 ? leds4 : leds1) : 32'(e.sel != 0 ? irq4 : irq1);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end
  function automatic vec_t v(input int op, input int sel, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] x, input string n);
    vec_t r;
    r.op = op; r.sel = sel; r.a = a; r.d = d; r.x = x; r.name = n;
    return r;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
    ne++;
  endtask
  task automatic push(input string n, input int sel, input int kind, input logic [31:0] x);
    exp_t e;
    e.name = n; e.sel = sel; e.kind = kind; e.exp = x;
    q.push_back(e);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; addr = a; writedata = d;
    cyc();
    memwrite = 1'b0;
  endtask
  task automatic chk(input string n, input int sel, input int kind, input logic [31:0] a, input logic [31:0] x);
    memwrite = 1'b0; addr = a;
    push(n, sel, kind, x);
    cyc();
  endtask
  task automatic wchk(input string n, input logic [31:0] a, input logic [31:0] d, input logic [31:0] x);
    memwrite = 1'b1; addr = a; writedata = d;
    push(n, 0, 1, x);
    cyc();
    memwrite = 1'b0;
  endtask
  initial begin
    tbl.push_back(v(1, 0, A_CNT,  0, 32'h0, "rst_cnt"));
    tbl.push_back(v(1, 0, A_CMP,  0, 32'hFFFF_FFFF, "rst_cmp"));
    tbl.push_back(v(1, 1, A_CTRL, 0, 32'h0, "rst_ctrl"));
    tbl.push_back(v(1, 1, A_STAT, 0, 32'h0, "rst_stat"));
    tbl.push_back(v(2, 0, 0, 0, 32'h0, "rst_leds"));
    tbl.push_back(v(3, 1, 0, 0, 32'h0, "rst_irq"));
    tbl.push_back(v(0, 0, 32'h04, 32'hDEAD_BEEF, 0, "w04"));
    tbl.push_back(v(0, 0, 32'h3C, 32'h1234_5678, 0, "w3c"));
    tbl.push_back(v(0, 0, 32'h00, 32'h0000_00A5, 0, "w00"));
    tbl.push_back(v(1, 0, 32'h04, 0, 32'hDEAD_BEEF, "ram_04"));
    tbl.push_back(v(1, 0, 32'h3C, 0, 32'h1234_5678, "ram_3c"));
    tbl.push_back(v(1, 1, 32'h07, 0, 32'hDEAD_BEEF, "ram_lowbits"));
    tbl.push_back(v(0, 0, 32'h100, 32'hFFFF_FFFF, 0, "w100"));
    tbl.push_back(v(1, 0, 32'h100, 0, 32'h0, "ram_oob"));
    tbl.push_back(v(1, 0, 32'h00, 0, 32'h0000_00A5, "ram_noalias0"));
    tbl.push_back(v(0, 0, 32'h0001_0004, 32'h1111_1111, 0, "wunmap"));
    tbl.push_back(v(1, 0, 32'h0001_0004, 0, 32'h0, "unmap_rd"));
    tbl.push_back(v(1, 0, 32'h04, 0, 32'hDEAD_BEEF, "ram_noalias4"));
    tbl.push_back(v(0, 0, A_LED, 32'hABCD_1234, 0, "wled"));
    tbl.push_back(v(2, 0, 0, 0, 32'h1234, "leds_out"));
    tbl.push_back(v(1, 0, A_LED, 0, 32'h0000_1234, "led_rd"));
    tbl.push_back(v(0, 0, 32'hFFFF_0020, 32'h5555_AAAA, 0, "wmmio_hole"));
    tbl.push_back(v(1, 0, 32'hFFFF_0020, 0, 32'h0, "mmio_hole_rd"));
    tbl.push_back(v(2, 1, 0, 0, 32'h1234, "leds_kept"));
    tbl.push_back(v(0, 0, A_CTRL, 32'hFFFF_FFFF, 0, "wctrl_all"));
    tbl.push_back(v(1, 0, A_CTRL, 0, 32'h7, "ctrl_mask"));
    tbl.push_back(v(0, 0, A_CTRL, 32'h0, 0, "wctrl_off"));
    tbl.push_back(v(0, 0, A_CNT, 32'h0, 0, "wcnt0"));
    tbl.push_back(v(4, 0, 32'h3C, 32'h0BAD_F00D, 32'h1234_5678, "rd_during_wr"));
    tbl.push_back(v(1, 0, 32'h3C, 0, 32'h0BAD_F00D, "ram_after_wr"));
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].op == 0) wr(tbl[i].a, tbl[i].d);
      else if (tbl[i].op == 4) wchk(tbl[i].name, tbl[i].a, tbl[i].d, tbl[i].x);
      else chk(tbl[i].name, tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].x);
    end
    // one-shot, prescale 1: match on 6th edge after enable
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h1);
    e0 = ne;
    while (ne - e0 < 5) chk("os_cnt", 0, 1, A_CNT, 32'(ne - e0));
    chk("os_stat_pre", 0, 1, A_STAT, 32'h0);
    chk("os_stat_set", 0, 1, A_STAT, 32'h1);
    chk("os_cnt_run", 0, 1, A_CNT, 32'd7);
    chk("os_irq_off", 0, 3, A_CNT, 32'h0);
    // auto-reload, prescale 4, CMP 3: match every 16 edges
    wr(A_CTRL, 32'h0);
    wr(A_CNT, 32'h0);
    wr(A_STAT, 32'h1);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
    e0 = ne;
    while (ne - e0 < 17) chk("ar_irq1", 1, 3, A_STAT, 32'(ne - e0 >= 16));
    chk("ar_reload", 1, 1, A_CNT, 32'h0);
    wr(A_STAT, 32'h1);
    while (ne - e0 < 33) chk("ar_irq2", 1, 3, A_STAT, 32'(ne - e0 >= 32));
    wr(A_STAT, 32'h1);
    while (ne - e0 < 47) chk("ar_idle", 1, 3, A_STAT, 32'h0);
    wr(A_STAT, 32'h1);
    chk("w1c_vs_match", 1, 1, A_STAT, 32'h1);
    chk("w1c_vs_match_irq", 1, 3, A_STAT, 32'h1);
    // CNT write beats tick and restarts prescaler
    wr(A_CNT, 32'hFFFF_FFFF);
    chk("col_u1_hold", 0, 1, A_CNT, 32'hFFFF_FFFF);
    chk("col_u1_wrap", 0, 1, A_CNT, 32'h0);
    chk("col_u4_hold2", 1, 1, A_CNT, 32'hFFFF_FFFF);
    chk("col_u4_hold3", 1, 1, A_CNT, 32'hFFFF_FFFF);
    chk("col_u4_wrap", 1, 1, A_CNT, 32'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_cnt", 0, 1, A_CNT, 32'h0);
    chk("mid_rst_ctrl", 0, 1, A_CTRL, 32'h0);
    chk("mid_rst_cmp", 1, 1, A_CMP, 32'hFFFF_FFFF);
    chk("mid_rst_stat", 1, 1, A_STAT, 32'h0);
    chk("mid_rst_leds", 0, 2, 0, 32'h0);
    chk("mid_rst_irq", 1, 3, 0, 32'h0);
    chk("mid_rst_ram04", 0, 1, 32'h04, 32'hDEAD_BEEF);
    chk("mid_rst_ram3c", 1, 1, 32'h3C, 32'h0BAD_F00D);
    cyc();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
